// File: rtl/fact_pkg.sv
// ============================================================================
// Module   : fact_pkg
// Brief    : Shared types and constants for the factorial result formatter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fact_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Largest n whose factorial still fits in 32 bits.
   localparam int FACT_MAX_N32 = 12;
   localparam int FACT_BIN_W   = 32;
   localparam int FACT_DIGITS  = 10;

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adj.sv
// ============================================================================
// Module   : bcd_digit_adj
// Brief    : Combinational double-dabble digit corrector (add 3 when >= 5).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_adj (
   input  logic [3:0] digit_in,
   output logic [3:0] digit_out
);

   assign digit_out = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;

endmodule

`default_nettype wire

// File: rtl/fact_bcd_conv.sv
// ============================================================================
// Module   : fact_bcd_conv
// Brief    : Sequential binary-to-BCD converter with valid/ready on both sides.
//            Optional overflow flag enabled by FACT_BCD_OVF_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fact_bcd_conv
   import fact_pkg::*;
#(
   parameter int BIN_W  = FACT_BIN_W,
   parameter int DIGITS = FACT_DIGITS
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [BIN_W-1:0]               in_bin,
`ifdef FACT_BCD_OVF_CHECK_EN
   input  logic [7:0]                     in_num,
   output logic                           out_ovf,
`endif
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [4*DIGITS-1:0]            out_bcd,
   output logic [$clog2(DIGITS+1)-1:0]    out_ndig
);

   localparam int NDIG_W = $clog2(DIGITS + 1);
   localparam int CNT_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

   state_t                state_q, state_d;
   logic [BIN_W-1:0]      bin_q, bin_d;
   logic [4*DIGITS-1:0]   bcd_q, bcd_d;
   logic [4*DIGITS-1:0]   bcd_adj;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [NDIG_W-1:0]     ndig;
`ifdef FACT_BCD_OVF_CHECK_EN
   logic                  ovf_q, ovf_d;
`endif

   for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit_in  (bcd_q[4*i +: 4]),
         .digit_out (bcd_adj[4*i +: 4])
      );
   end

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
`ifdef FACT_BCD_OVF_CHECK_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               bin_d   = in_bin;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = ST_SHIFT;
`ifdef FACT_BCD_OVF_CHECK_EN
               ovf_d   = (in_num > 8'(FACT_MAX_N32));
`endif
            end
         end
         ST_SHIFT: begin
            // Corrected digits and binary MSB shift together as one wide register.
            bcd_d = {bcd_adj[4*DIGITS-2:0], bin_q[BIN_W-1]};
            bin_d = bin_q << 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ndig = NDIG_W'(1);
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[4*i +: 4] != 4'd0) begin
            ndig = NDIG_W'(i + 1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
`ifdef FACT_BCD_OVF_CHECK_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
`ifdef FACT_BCD_OVF_CHECK_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign out_bcd   = bcd_q;
   assign out_ndig  = ndig;
`ifdef FACT_BCD_OVF_CHECK_EN
   assign out_ovf   = ovf_q;
`endif

endmodule

`default_nettype wire
